// File: rtl/cv32e40s_irq_arbiter_if.sv
// Request/acknowledge channel between the interrupt arbiter and the core controller.
interface cv32e40s_irq_arbiter_if #(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 3
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic              irq_req_o;
  logic [ID_W-1:0]   irq_id_o;
  logic [PRIO_W-1:0] irq_prio_o;
  logic              irq_ack_i;

  modport master (output irq_req_o, irq_id_o, irq_prio_o, input irq_ack_i);
  modport slave  (input irq_req_o, irq_id_o, irq_prio_o, output irq_ack_i);
endinterface

// File: rtl/cv32e40s_irq_arbiter.sv
// Parametrised priority/threshold interrupt arbiter with a frozen req/ack handshake.
// Edge-triggered pending latches are built only when CV32E40S_IRQ_EDGE_EN is defined.
//
// state  | meaning
// IDLE   | no request; latch the winner when any line is eligible
// REQ    | request presented, ID/priority frozen until ack or withdraw
// WAIT   | one-cycle gap after ack so the controller can update CSRs
module cv32e40s_irq_arbiter #(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IRQ-1:0]          irq_i,
  input  logic [NUM_IRQ-1:0]          irq_ie_i,
  input  logic [NUM_IRQ-1:0]          irq_trig_i,
  input  logic [NUM_IRQ*PRIO_W-1:0]   irq_prio_i,
  input  logic [PRIO_W-1:0]           thresh_i,
  input  logic                        global_en_i,
  cv32e40s_irq_arbiter_if.master      irq_bus,
  output logic [NUM_IRQ-1:0]          pending_o,
  output logic                        irq_wu_o
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_q, pend_q, elig, sel;
  logic [PRIO_W-1:0]   line_prio [NUM_IRQ];
  logic                win_found, lat_elig, latch_en, req;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;

  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_i;
  end

`ifdef CV32E40S_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev, rise, ack_clr;

  assign rise    = irq_q & ~irq_prev;
  assign ack_clr = (state_q == S_REQ && irq_bus.irq_ack_i) ? sel : '0;

  // Level lines follow irq_q, which also discards any latch left from edge mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_prev <= '0;
      pend_q   <= '0;
    end else begin
      irq_prev <= irq_q;
      pend_q   <= (irq_trig_i & ((pend_q & ~ack_clr) | rise)) | (~irq_trig_i & irq_q);
    end
  end
`else
  logic unused_trig;
  assign unused_trig = ^irq_trig_i;

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= irq_q;
  end
`endif

  always_comb begin
    for (int n = 0; n < NUM_IRQ; n++) begin
      line_prio[n] = irq_prio_i[n*PRIO_W +: PRIO_W];
      elig[n]      = pend_q[n] & irq_ie_i[n] & (line_prio[n] > thresh_i) & global_en_i;
      sel[n]       = (irq_bus.irq_id_o == ID_W'(n));
    end
  end

  assign lat_elig = |(elig & sel);

  // Ascending scan with >= lets the highest index win a priority tie.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (elig[n] && (!win_found || line_prio[n] >= win_prio)) begin
        win_found = 1'b1;
        win_id    = ID_W'(n);
        win_prio  = line_prio[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = S_REQ;
      S_REQ: begin
        if (irq_bus.irq_ack_i) state_d = S_WAIT;
        else if (!lat_elig)    state_d = S_IDLE;
      end
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req      = (state_q == S_REQ);
    latch_en = (state_q == S_IDLE) && win_found;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_bus.irq_id_o   <= '0;
      irq_bus.irq_prio_o <= '0;
    end else if (latch_en) begin
      irq_bus.irq_id_o   <= win_id;
      irq_bus.irq_prio_o <= win_prio;
    end
  end

  assign irq_bus.irq_req_o = req;
  assign pending_o         = pend_q;
  assign irq_wu_o          = |(irq_i & irq_ie_i);
endmodule

// File: tb/tb_cv32e40s_irq_arbiter.sv
// Directed plus randomised bench for cv32e40s_irq_arbiter against a cycle-level reference model.
module tb_cv32e40s_irq_arbiter;
`ifdef CV32E40S_IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk, rst_n;
  logic [31:0] irq_i, irq_ie_i, irq_trig_i, pending_o;
  logic [95:0] irq_prio_i;
  logic [2:0]  thresh_i;
  logic        global_en_i, irq_wu_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [31:0] m_q, m_prev, m_pend;
  int        m_phase;  // 0 quiet, 1 presenting, 2 gap after ack
  int        m_id, m_prio;

  cv32e40s_irq_arbiter_if #(.NUM_IRQ(32), .PRIO_W(3)) irq_bus ();

  cv32e40s_irq_arbiter #(.NUM_IRQ(32), .PRIO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_ie_i(irq_ie_i),
    .irq_trig_i(irq_trig_i), .irq_prio_i(irq_prio_i), .thresh_i(thresh_i),
    .global_en_i(global_en_i), .irq_bus(irq_bus), .pending_o(pending_o),
    .irq_wu_o(irq_wu_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pr(int n);
    return int'(irq_prio_i[n*3 +: 3]);
  endfunction

  function automatic bit m_elig(int n);
    return m_pend[n] && irq_ie_i[n] && (pr(n) > int'(thresh_i)) && global_en_i;
  endfunction

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int best, clr;
    bit [31:0] np;
    if (!rst_n) begin
      m_q = '0; m_prev = '0; m_pend = '0; m_phase = 0; m_id = 0; m_prio = 0;
      return;
    end
    best = -1;
    for (int n = 0; n < 32; n++)
      if (m_elig(n) && pr(n) * 64 + n > best) best = pr(n) * 64 + n;
    clr = -1;
    case (m_phase)
      0: if (best >= 0) begin m_phase = 1; m_id = best % 64; m_prio = best / 64; end
      1: begin
        if (irq_bus.irq_ack_i) begin m_phase = 2; clr = m_id; end
        else if (!m_elig(m_id)) m_phase = 0;
      end
      default: m_phase = 0;
    endcase
    for (int n = 0; n < 32; n++) begin
      if (EDGE && irq_trig_i[n]) np[n] = (m_pend[n] && clr != n) || (m_q[n] && !m_prev[n]);
      else                       np[n] = m_q[n];
    end
    m_prev = m_q;
    m_q    = irq_i;
    m_pend = np;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".req"},  irq_bus.irq_req_o, (m_phase == 1));
    chk({tag, ".id"},   irq_bus.irq_id_o, m_id);
    chk({tag, ".prio"}, irq_bus.irq_prio_o, m_prio);
    chk({tag, ".pend"}, pending_o, m_pend);
    chk({tag, ".wu"},   irq_wu_o, |(irq_i & irq_ie_i));
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic wait_req(string tag, int budget);
    int i = 0;
    while (!irq_bus.irq_req_o && i < budget) begin
      tick(tag);
      i++;
    end
    chk({tag, ".req_seen"}, irq_bus.irq_req_o, 1'b1);
  endtask

  task automatic set_prio(int n, int p);
    irq_prio_i[n*3 +: 3] = 3'(p);
  endtask

  initial begin
    rst_n = 1'b0; irq_i = '1; irq_ie_i = '1; irq_trig_i = '0; irq_prio_i = '1;
    thresh_i = '0; global_en_i = 1'b1; irq_bus.irq_ack_i = 1'b0;

    // reset held with all lines high
    tick("rst0");
    tick("rst1");
    chk("rst.req", irq_bus.irq_req_o, 1'b0);
    chk("rst.id", irq_bus.irq_id_o, 0);
    chk("rst.pend", pending_o, 0);
    rst_n = 1'b1;
    tick("rel0");
    chk("rel0.req", irq_bus.irq_req_o, 1'b0);
    tick("rel1");
    chk("rel1.req", irq_bus.irq_req_o, 1'b0);
    tick("rel2");
    chk("rel2.req", irq_bus.irq_req_o, 1'b1);
    chk("rel2.id", irq_bus.irq_id_o, 31);
    irq_bus.irq_ack_i = 1'b1;
    tick("ack0");
    chk("ack0.req", irq_bus.irq_req_o, 1'b0);
    irq_bus.irq_ack_i = 1'b0;
    tick("ack1");
    chk("ack1.req", irq_bus.irq_req_o, 1'b0);
    tick("ack2");
    chk("ack2.req", irq_bus.irq_req_o, 1'b1);
    irq_i = '0;
    repeat (5) tick("drain0");
    chk("drain0.req", irq_bus.irq_req_o, 1'b0);

    // priority and tie-break
    irq_prio_i = '0; thresh_i = 3'd1;
    set_prio(3, 2); set_prio(11, 5);
    irq_i[3] = 1'b1; irq_i[11] = 1'b1;
    wait_req("prio", 6);
    chk("prio.id", irq_bus.irq_id_o, 11);
    chk("prio.prio", irq_bus.irq_prio_o, 5);
    set_prio(20, 5); irq_i[20] = 1'b1; irq_bus.irq_ack_i = 1'b1;
    tick("tie.ack");
    irq_bus.irq_ack_i = 1'b0;
    wait_req("tie", 6);
    chk("tie.id", irq_bus.irq_id_o, 20);
    irq_i = '0;
    repeat (5) tick("drain1");

    // threshold and withdraw
    irq_prio_i = '0; set_prio(7, 3); thresh_i = 3'd3; irq_i[7] = 1'b1;
    repeat (4) tick("thr.block");
    chk("thr.block.req", irq_bus.irq_req_o, 1'b0);
    thresh_i = 3'd2;
    wait_req("thr", 6);
    chk("thr.id", irq_bus.irq_id_o, 7);
    thresh_i = 3'd4;
    tick("wdraw");
    chk("wdraw.req", irq_bus.irq_req_o, 1'b0);
    irq_i = '0;
    repeat (3) tick("drain2");

    // stability: higher priority arrival while presenting
    irq_prio_i = '0; set_prio(3, 2); set_prio(30, 6); thresh_i = 3'd1; irq_i[3] = 1'b1;
    wait_req("stab", 6);
    chk("stab.id0", irq_bus.irq_id_o, 3);
    irq_i[30] = 1'b1;
    repeat (4) begin
      tick("stab.hold");
      chk("stab.hold.id", irq_bus.irq_id_o, 3);
      chk("stab.hold.req", irq_bus.irq_req_o, 1'b1);
    end
    irq_bus.irq_ack_i = 1'b1;
    tick("stab.ack");
    irq_bus.irq_ack_i = 1'b0;
    chk("stab.wait.req", irq_bus.irq_req_o, 1'b0);
    wait_req("stab.next", 6);
    chk("stab.next.id", irq_bus.irq_id_o, 30);
    irq_i = '0;
    repeat (5) tick("drain3");

    // wake-up ignores global enable and threshold
    irq_ie_i = 32'h20; global_en_i = 1'b0; set_prio(5, 7); thresh_i = 3'd0;
    irq_i[5] = 1'b1;
    #1;
    chk("wu", irq_wu_o, 1'b1);
    repeat (3) begin
      tick("wu.noreq");
      chk("wu.noreq.req", irq_bus.irq_req_o, 1'b0);
    end
    irq_i = '0; irq_ie_i = '1; global_en_i = 1'b1;
    repeat (4) tick("drain4");

`ifdef CV32E40S_IRQ_EDGE_EN
    // edge mode: pulse capture, ack clear, set-wins-over-clear
    irq_prio_i = '0; set_prio(16, 4); thresh_i = 3'd1; irq_trig_i[16] = 1'b1;
    irq_i[16] = 1'b1;
    tick("edge.p");
    irq_i[16] = 1'b0;
    wait_req("edge", 6);
    chk("edge.id", irq_bus.irq_id_o, 16);
    tick("edge.hold");
    chk("edge.hold.pend", pending_o[16], 1'b1);
    irq_bus.irq_ack_i = 1'b1;
    tick("edge.ack");
    irq_bus.irq_ack_i = 1'b0;
    chk("edge.ack.pend", pending_o[16], 1'b0);
    chk("edge.ack.req", irq_bus.irq_req_o, 1'b0);
    repeat (3) tick("edge.idle");
    chk("edge.idle.req", irq_bus.irq_req_o, 1'b0);
    irq_i[16] = 1'b1;
    tick("edge.p2");
    irq_i[16] = 1'b0;
    wait_req("edge2", 6);
    irq_i[16] = 1'b1;
    tick("edge.pre");
    irq_i[16] = 1'b0; irq_bus.irq_ack_i = 1'b1;
    tick("edge.setclr");
    irq_bus.irq_ack_i = 1'b0;
    chk("edge.setclr.pend", pending_o[16], 1'b1);
    wait_req("edge3", 6);
    irq_bus.irq_ack_i = 1'b1;
    tick("edge.ack3");
    irq_bus.irq_ack_i = 1'b0; irq_trig_i = '0;
    repeat (4) tick("drain5");
`endif

    // randomised traffic, including acks outside REQ and occasional resets
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        irq_ie_i    = $urandom | $urandom;
        irq_trig_i  = $urandom;
        irq_prio_i  = {$urandom, $urandom, $urandom};
        thresh_i    = 3'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 3) == 0) irq_i = $urandom & $urandom & $urandom;
      global_en_i       = ($urandom_range(0, 7) != 0);
      irq_bus.irq_ack_i = ($urandom_range(0, 2) == 0);
      rst_n             = ($urandom_range(0, 79) != 0);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
